// File: rtl/SDRAMPkg.sv
// Shared types for the SDRAM front-end arbiter: command encoding and arbiter FSM states.
package SDRAMPkg;

  // Packed as {w, r} so a command drives the controller strobes directly.
  typedef logic [1:0] SDRAMCmd;

  localparam SDRAMCmd CMD_NOP   = 2'b00;
  localparam SDRAMCmd CMD_READ  = 2'b01;
  localparam SDRAMCmd CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAITB,
    WAITD
  } ArbState;

endpackage

// File: rtl/RRPick.sv
// Combinational round-robin picker: first requester found searching upward from last+1.
module RRPick #(
  parameter int unsigned ports = 2,
  parameter int unsigned IW    = 1
) (
  input  logic [ports-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    grant,
  output logic             valid
);

  int unsigned idx;
  logic [IW-1:0] ix;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    ix    = '0;
    for (int unsigned i = 1; i <= ports; i++) begin
      idx = (32'(last) + i) % ports;
      ix  = IW'(idx);
      if (!valid && req[ix]) begin
        valid = 1'b1;
        grant = ix;
      end
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Round-robin arbiter sharing one SDRAM controller port among several requesters,
// one outstanding transaction at a time.
module sdram_arb
  import SDRAMPkg::*;
#(
  parameter int unsigned ports    = 2,
  parameter int unsigned addrBits = 24,
  parameter int unsigned dataBits = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [ports-1:0]                   req,
  input  logic [ports-1:0]                   we,
  input  logic [ports-1:0][addrBits-1:0]     addr,
  input  logic [ports-1:0][dataBits-1:0]     wdata,
  output logic [ports-1:0]                   ack,
  output logic [ports-1:0]                   rvalid,
  output logic [dataBits-1:0]                rdata,
  output logic [addrBits-1:0]                mAddr,
  output logic                               mR,
  output logic                               mW,
  output logic [dataBits-1:0]                mDw,
  input  logic [dataBits-1:0]                mDr,
  input  logic                               mBusy
);

  localparam int unsigned IW = (ports > 1) ? $clog2(ports) : 1;

  ArbState               state, state_n;
  logic [IW-1:0]         last, g, pick;
  logic                  pick_valid;
  SDRAMCmd               lcmd;
  logic [addrBits-1:0]   laddr;
  logic [dataBits-1:0]   ldata;
  logic                  cool;
  logic                  do_grant, do_issue, do_done;

  RRPick #(
    .ports(ports),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .last (last),
    .grant(pick),
    .valid(pick_valid)
  );

  // cool holds off a grant for the IDLE cycle right after completion (the rvalid cycle).
  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    do_issue = 1'b0;
    do_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid && !mBusy && !cool) begin
          do_grant = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        do_issue = 1'b1;
        state_n  = WAITB;
      end
      WAITB: begin
        if (mBusy) state_n = WAITD;
      end
      WAITD: begin
        if (!mBusy) begin
          do_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last     <= IW'(ports - 1);
      g        <= '0;
      lcmd     <= CMD_NOP;
      laddr    <= '0;
      ldata    <= '0;
      cool     <= 1'b0;
      ack      <= '0;
      rvalid   <= '0;
      {mW, mR} <= CMD_NOP;
      mAddr    <= '0;
      mDw      <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_n;
      ack      <= '0;
      rvalid   <= '0;
      {mW, mR} <= CMD_NOP;
      cool     <= do_done;
      if (do_grant) begin
        g     <= pick;
        last  <= pick;
        lcmd  <= we[pick] ? CMD_WRITE : CMD_READ;
        laddr <= addr[pick];
        ldata <= wdata[pick];
      end
      if (do_issue) begin
        ack[g]   <= 1'b1;
        {mW, mR} <= lcmd;
        mAddr    <= laddr;
        mDw      <= ldata;
      end
      if (do_done && lcmd == CMD_READ) begin
        rdata     <= mDr;
        rvalid[g] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Randomized scoreboard bench for sdram_arb (4 ports) with a behavioural SDRAM controller.
module tb_sdram_arb;

  localparam int P  = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rstn;
  logic [P-1:0] req, we;
  logic [P-1:0][AW-1:0] addr;
  logic [P-1:0][DW-1:0] wdata;
  logic [P-1:0] ack, rvalid;
  logic [DW-1:0] rdata, mDw;
  logic [AW-1:0] mAddr;
  logic mR, mW, mBusy;
  bit   [DW-1:0] mDr;

  always #5 clk = ~clk;

  sdram_arb #(.ports(P), .addrBits(AW), .dataBits(DW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .mAddr(mAddr), .mR(mR), .mW(mW),
    .mDw(mDw), .mDr(mDr), .mBusy(mBusy)
  );

  // Behavioural controller: busy for lat cycles after accepting, read data valid as busy falls.
  logic stuck;
  int unsigned lat;
  bit [DW-1:0] cmem [4096];
  bit [DW-1:0] cpend;
  int unsigned ccnt;
  assign mBusy = stuck || (ccnt != 0);

  always @(posedge clk) begin
    if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) mDr <= cpend;
    end else if (!stuck && (mR || mW)) begin
      ccnt <= lat;
      if (mW) cmem[mAddr[11:0]] <= mDw;
      else    cpend <= cmem[mAddr[11:0]];
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
  typedef struct { int p; logic [DW-1:0] d; } rd_t;

  txn_t pq [P][$];
  rd_t  rexp [$];
  int   glog [$];
  logic [DW-1:0] rmem [logic [AW-1:0]];
  int ackc [P];
  int rvc  [P];
  int rcyc = 0, wcyc = 0;
  int last_ref = P - 1;
  logic [DW-1:0] rdhold = '0;

  function automatic int rr_next(input int lst, input logic [P-1:0] r);
    for (int k = 1; k <= P; k++) begin
      int c;
      c = (lst + k) % P;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: pops the expected transaction at each ack, expected read data at each rvalid.
  initial begin
    logic [P-1:0] rh1, rh2;
    logic bh1, bh2;
    int p;
    txn_t t;
    rd_t e;
    rh1 = '0; rh2 = '0; bh1 = 1'b0; bh2 = 1'b0;
    for (int i = 0; i < P; i++) begin ackc[i] = 0; rvc[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rstn) begin
        for (int i = 0; i < P; i++) pq[i].delete();
        rexp.delete();
        last_ref = P - 1;
        rdhold = '0;
        rh1 = '0; rh2 = '0; bh1 = 1'b0; bh2 = 1'b0;
        continue;
      end
      if (mR || mW || (|ack)) begin
        chk("mr_mw_exclusive", {31'd0, mR & mW}, 0);
        chk("ack_onehot", {31'd0, $onehot(ack)}, 1);
        chk("issue_with_ack", {31'd0, mR | mW}, {31'd0, |ack});
        chk("issue_while_busy", {31'd0, mBusy}, 0);
        if ($onehot(ack)) begin
          p = 0;
          for (int i = 0; i < P; i++) if (ack[i]) p = i;
          ackc[p]++;
          glog.push_back(p);
          chk("rr_grant", p, rr_next(last_ref, rh2));
          last_ref = p;
          if (pq[p].size() == 0) begin
            chk("ack_without_request", p, 32'hFFFF_FFFF);
          end else begin
            t = pq[p].pop_front();
            chk("mW", {31'd0, mW}, {31'd0, t.w});
            chk("mR", {31'd0, mR}, {31'd0, !t.w});
            chk("mAddr", mAddr, t.a);
            if (t.w) begin
              chk("mDw", mDw, t.d);
              rmem[t.a] = t.d;
            end else begin
              e.p = p;
              e.d = rmem.exists(t.a) ? rmem[t.a] : '0;
              rexp.push_back(e);
            end
          end
        end
      end
      if (mR) rcyc++;
      if (mW) wcyc++;
      if (|rvalid) begin
        chk("rvalid_onehot", {31'd0, $onehot(rvalid)}, 1);
        p = 0;
        for (int i = 0; i < P; i++) if (rvalid[i]) p = i;
        rvc[p]++;
        chk("rvalid_after_busy_fall", {30'd0, bh2, bh1}, 2'b10);
        if (rexp.size() == 0) begin
          chk("unexpected_rvalid", p, 32'hFFFF_FFFF);
        end else begin
          e = rexp.pop_front();
          chk("rvalid_port", p, e.p);
          chk("rdata", rdata, e.d);
          rdhold = e.d;
        end
      end else begin
        chk("rdata_hold", rdata, rdhold);
      end
      rh2 = rh1; rh1 = req;
      bh2 = bh1; bh1 = mBusy;
    end
  end

  always @(negedge clk)
    if (rstn)
      assert ($onehot0(ack) && $onehot0(rvalid) && !(mR && mW))
      else $error("FAIL onehot_assert: ack=%b rvalid=%b mR=%b mW=%b required one-hot-or-zero", ack, rvalid, mR, mW);

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic new_txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.w = w; t.a = a; t.d = d;
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    pq[p].push_back(t);
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #2; n++;
      if (ack[p]) break;
    end
    chk("ack_seen", {31'd0, ack[p]}, 1);
    req[p] = 1'b0;
  endtask

  task automatic wait_quiet();
    int q;
    q = 0;
    for (int i = 0; i < 400 && q < 4; i++) begin
      @(posedge clk); #2;
      if (!mBusy && req == '0 && rexp.size() == 0) q++;
      else q = 0;
    end
    chk("quiet", q, 4);
  endtask

  task automatic traffic(input int n, input logic [P-1:0] mask, input bit cont, input bit rlat);
    int done, started, cyc;
    done = 0; started = 0; cyc = 0;
    while ((done < n || req != '0) && cyc < 20000) begin
      @(posedge clk); #2; cyc++;
      if (rlat) lat = $urandom_range(1, 6);
      for (int p = 0; p < P; p++)
        if (req[p] && ack[p]) begin done++; req[p] = 1'b0; end
      for (int p = 0; p < P; p++)
        if (!req[p] && mask[p] && started < n && (cont || $urandom_range(0, 3) == 0)) begin
          new_txn(p, cont ? logic'(started % 2) : logic'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 255)), DW'($urandom));
          started++;
        end
    end
    chk("traffic_acks", done, n);
    wait_quiet();
  endtask

  initial begin
    int n, a0, a1, r0, w0, rv0, rv1, base, nack;
    rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    stuck = 1'b0; lat = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {28'd0, ack}, 0);
    chk("rst_rvalid", {28'd0, rvalid}, 0);
    chk("rst_mr_mw", {30'd0, mR, mW}, 0);
    chk("rst_maddr", mAddr, 0);
    chk("rst_mdw", mDw, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #2; rstn = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Store 0xBEEF, then read it back on port 0 with a 5-cycle busy.
    new_txn(2, 1'b1, 24'h000123, 16'hBEEF);
    wait_ack(2, n);
    wait_quiet();
    lat = 5;
    a0 = ackc[0]; r0 = rcyc; w0 = wcyc; rv0 = rvc[0];
    new_txn(0, 1'b0, 24'h000123, 16'h0000);
    wait_ack(0, n);
    chk("read_ack_latency", n, 2);
    wait_quiet();
    chk("read_ack_count", ackc[0] - a0, 1);
    chk("read_mr_cycles", rcyc - r0, 1);
    chk("read_mw_cycles", wcyc - w0, 0);
    chk("read_rvalid_count", rvc[0] - rv0, 1);
    chk("read_rdata", rdata, 16'hBEEF);

    // Port 1 write: single mW cycle, no rvalid.
    lat = 3;
    a1 = ackc[1]; r0 = rcyc; w0 = wcyc;
    rv0 = rvc[0] + rvc[1] + rvc[2] + rvc[3];
    new_txn(1, 1'b1, 24'h00FFFF, 16'h5A5A);
    wait_ack(1, n);
    wait_quiet();
    chk("write_ack_count", ackc[1] - a1, 1);
    chk("write_mw_cycles", wcyc - w0, 1);
    chk("write_mr_cycles", rcyc - r0, 0);
    chk("write_no_rvalid", rvc[0] + rvc[1] + rvc[2] + rvc[3] - rv0, 0);

    // Controller stuck busy: nothing may issue until it frees up.
    stuck = 1'b1;
    @(posedge clk); #2;
    nack = ackc[0] + ackc[1] + ackc[2] + ackc[3]; r0 = rcyc; w0 = wcyc;
    new_txn(0, 1'b0, 24'h000040, 16'h0000);
    repeat (20) @(posedge clk);
    #2;
    chk("stuck_no_ack", ackc[0] + ackc[1] + ackc[2] + ackc[3] - nack, 0);
    chk("stuck_no_cmd", (rcyc - r0) + (wcyc - w0), 0);
    stuck = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk); #2; n++;
      if (ack[0]) break;
    end
    chk("unstuck_issue_within_2", {31'd0, n <= 2 && ack[0]}, 1);
    req[0] = 1'b0;
    wait_quiet();

    // Reset while a port-1 read waits for data.
    lat = 10;
    new_txn(1, 1'b0, 24'h000050, 16'h0000);
    wait_ack(1, n);
    n = 0;
    while (!mBusy && n < 20) begin @(posedge clk); #2; n++; end
    repeat (2) @(posedge clk);
    #2;
    chk("in_waitd_busy", {31'd0, mBusy}, 1);
    rv1 = rvc[0] + rvc[1] + rvc[2] + rvc[3];
    rstn = 1'b0;
    #1;
    chk("midrst_ack", {28'd0, ack}, 0);
    chk("midrst_rvalid", {28'd0, rvalid}, 0);
    chk("midrst_mr_mw", {30'd0, mR, mW}, 0);
    chk("midrst_maddr", mAddr, 0);
    chk("midrst_rdata", rdata, 0);
    repeat (3) @(posedge clk);
    #2; rstn = 1'b1;
    n = 0;
    while (mBusy && n < 40) begin @(posedge clk); #2; n++; end
    repeat (3) @(posedge clk);
    #2;
    chk("abandoned_no_rvalid", rvc[0] + rvc[1] + rvc[2] + rvc[3] - rv1, 0);

    // All four ports continuously: 0,1,2,3,0,1,2,3 starting from reset.
    lat = 2;
    base = glog.size();
    traffic(8, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      chk("grant_order4", (base + i < glog.size()) ? glog[base + i] : -1, i % 4);

    // Two ports continuously: strict alternation.
    base = glog.size();
    traffic(8, 4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      chk("grant_order2", (base + i < glog.size()) ? glog[base + i] : -1, i % 2);

    // Random traffic, random controller latency.
    traffic(300, 4'hF, 1'b0, 1'b1);
    chk("rexp_drained", rexp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
